// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the reg_native round-robin arbiter.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    // Width of a master index; never below one bit so degenerate configs still elaborate.
    function automatic int gnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester at or above ptr_i, wrapping to 0.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int N = 2,
    parameter int W = gnt_w(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int off = 0; off < N; off++) begin
            for (int j = 0; j < N; j++) begin
                if (!any_o && req_i[j] && (j == ((int'(ptr_i) + off) % N))) begin
                    any_o    = 1'b1;
                    gnt_o[j] = 1'b1;
                    idx_o    = W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/reg_native_arb.sv
// Round-robin arbiter sharing one downstream reg_native port among MST_NUM masters,
// with a per-transaction timeout that aborts hung downstream accesses.
module reg_native_arb
    import reg_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32,
    parameter int MST_NUM    = 2,
    parameter int TMO_CYC    = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           glb_srst_up,
    output logic                           glb_srst_down,
    input  logic [MST_NUM-1:0]             req_vld_up,
    input  logic [MST_NUM-1:0]             rd_en_up,
    input  logic [MST_NUM-1:0]             wr_en_up,
    input  logic [MST_NUM*ADDR_WIDTH-1:0]  addr_up,
    input  logic [MST_NUM*DATA_WIDTH-1:0]  wr_data_up,
    output logic [MST_NUM-1:0]             req_rdy_up,
    output logic [MST_NUM-1:0]             ack_vld_up,
    input  logic [MST_NUM-1:0]             ack_rdy_up,
    output logic [DATA_WIDTH-1:0]          rd_data_up,
    output logic                           req_vld_down,
    output logic                           rd_en_down,
    output logic                           wr_en_down,
    output logic [ADDR_WIDTH-1:0]          addr_down,
    output logic [DATA_WIDTH-1:0]          wr_data_down,
    input  logic                           req_rdy_down,
    input  logic                           ack_vld_down,
    output logic                           ack_rdy_down,
    input  logic [DATA_WIDTH-1:0]          rd_data_down,
    output logic [$clog2(MST_NUM)-1:0]     gnt_id,
    output logic                           tmo_err
);

    localparam int GW = gnt_w(MST_NUM);
    localparam int CW = $clog2(TMO_CYC + 1);

    arb_state_e            state_q, state_d;
    logic [GW-1:0]         ptr_q, ptr_d;
    logic [GW-1:0]         gnt_q, gnt_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rd_q, rd_d, wr_q, wr_d, tmo_q, tmo_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;

    logic [MST_NUM-1:0]    pick_gnt;
    logic [GW-1:0]         pick_idx;
    logic                  pick_any;
    logic                  tmo_hit;

    rr_pick #(.N(MST_NUM), .W(GW)) u_rr_pick (
        .req_i (req_vld_up),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // The counter spans REQ and ACK together, so a late REQ handshake still leaves a bounded ACK wait.
    assign tmo_hit = (cnt_q >= CW'(TMO_CYC - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        tmo_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                    gnt_d   = pick_idx;
                    rd_d    = rd_en_up[pick_idx];
                    wr_d    = wr_en_up[pick_idx];
                    addr_d  = addr_up[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = wr_data_up[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            ST_REQ: begin
                if (req_rdy_down) begin
                    state_d = ST_ACK;
                    cnt_d   = cnt_q + 1'b1;
                end else if (tmo_hit) begin
                    state_d = ST_RESP;
                    rdata_d = '0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACK: begin
                if (ack_vld_down) begin
                    state_d = ST_RESP;
                    rdata_d = rd_data_down;
                end else if (tmo_hit) begin
                    state_d = ST_RESP;
                    rdata_d = '0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (ack_rdy_up[gnt_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = (gnt_q == GW'(MST_NUM - 1)) ? '0 : gnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || glb_srst_up) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        ack_vld_up = '0;
        if (state_q == ST_RESP) ack_vld_up[gnt_q] = 1'b1;
    end

    // IDLE keeps ack_rdy_down high so a late ack from an aborted access drains harmlessly.
    assign req_rdy_up    = (state_q == ST_IDLE) ? pick_gnt : '0;
    assign rd_data_up    = rdata_q;
    assign req_vld_down  = (state_q == ST_REQ);
    assign rd_en_down    = (state_q == ST_REQ) && rd_q;
    assign wr_en_down    = (state_q == ST_REQ) && wr_q;
    assign addr_down     = addr_q;
    assign wr_data_down  = wdata_q;
    assign ack_rdy_down  = (state_q == ST_IDLE) || (state_q == ST_ACK);
    assign gnt_id        = gnt_q;
    assign tmo_err       = tmo_q;
    assign glb_srst_down = glb_srst_up;

endmodule

// File: tb/tb_reg_native_arb.sv
// Self-checking bench for reg_native_arb: randomized transactions against a
// phase-timeline reference model of the arbiter.
module tb_reg_native_arb;

    localparam int AW  = 64;
    localparam int DW  = 32;
    localparam int N   = 3;
    localparam int TMO = 12;
    localparam int GW  = $clog2(N);
    localparam int RW  = 5 + N + GW + DW + AW + DW;

    logic            clk;
    logic            rst_n, glb_srst_up, glb_srst_down;
    logic [N-1:0]    req_vld_up, rd_en_up, wr_en_up, req_rdy_up, ack_vld_up, ack_rdy_up;
    logic [N*AW-1:0] addr_up;
    logic [N*DW-1:0] wr_data_up;
    logic [DW-1:0]   rd_data_up, wr_data_down, rd_data_down;
    logic            req_vld_down, rd_en_down, wr_en_down;
    logic            req_rdy_down, ack_vld_down, ack_rdy_down, tmo_err;
    logic [AW-1:0]   addr_down;
    logic [GW-1:0]   gnt_id;

    int nChecks = 0;
    int nPass   = 0;
    int mdlPtr  = 0;

    reg_native_arb #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MST_NUM    (N),
        .TMO_CYC    (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .glb_srst_up   (glb_srst_up),
        .glb_srst_down (glb_srst_down),
        .req_vld_up    (req_vld_up),
        .rd_en_up      (rd_en_up),
        .wr_en_up      (wr_en_up),
        .addr_up       (addr_up),
        .wr_data_up    (wr_data_up),
        .req_rdy_up    (req_rdy_up),
        .ack_vld_up    (ack_vld_up),
        .ack_rdy_up    (ack_rdy_up),
        .rd_data_up    (rd_data_up),
        .req_vld_down  (req_vld_down),
        .rd_en_down    (rd_en_down),
        .wr_en_down    (wr_en_down),
        .addr_down     (addr_down),
        .wr_data_down  (wr_data_down),
        .req_rdy_down  (req_rdy_down),
        .ack_vld_down  (ack_vld_down),
        .ack_rdy_down  (ack_rdy_down),
        .rd_data_down  (rd_data_down),
        .gnt_id        (gnt_id),
        .tmo_err       (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference round-robin rule: first requester at or after the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic randFields();
        for (int i = 0; i < N; i++) begin
            addr_up[i*AW +: AW]    = {$urandom, $urandom};
            wr_data_up[i*DW +: DW] = $urandom;
            rd_en_up[i]            = 1'($urandom_range(0, 1));
            wr_en_up[i]            = ~rd_en_up[i];
        end
    endtask

    // Runs one transaction from IDLE; the model derives every phase boundary from the
    // chosen downstream/upstream delays and the timeout rule, then checks each cycle.
    task automatic do_txn(input logic [N-1:0] reqs, input int reqDly, input int ackDly,
                          input int upDly, input logic [DW-1:0] rdata, output int gotGnt);
        int w, reqEnd, ackC, endC, respStart, lastC, lastAbort;
        bit abort, inReq, inAck, inResp;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, erd;
        logic          eRd, eWr;
        logic [N-1:0]  oh;
        logic [N+4:0]  expCtrl, gotCtrl;
        w   = pick(reqs, mdlPtr);
        oh  = N'(1) << w;
        ea  = addr_up[w*AW +: AW];
        ed  = wr_data_up[w*DW +: DW];
        eRd = rd_en_up[w];
        eWr = wr_en_up[w];
        req_vld_up = reqs;
        #1;
        nChecks++;
        if (req_rdy_up !== oh) $display("[TB] FAIL req_rdy_up: got %b want %b", req_rdy_up, oh);
        else nPass++;

        if (reqDly > TMO - 1) begin
            abort  = 1'b1;
            reqEnd = TMO - 1;
            endC   = TMO - 1;
            ackC   = -1;
        end else begin
            reqEnd    = reqDly;
            ackC      = reqDly + 1 + ackDly;
            lastAbort = (reqDly + 1 > TMO - 1) ? reqDly + 1 : TMO - 1;
            abort     = (ackC > lastAbort);
            endC      = abort ? lastAbort : ackC;
        end
        respStart = endC + 1;
        lastC     = respStart + upDly;
        erd       = abort ? '0 : rdata;

        @(posedge clk); #1;
        req_vld_up = '0;
        for (int c = 0; c <= lastC; c++) begin
            inReq  = (c <= reqEnd);
            inAck  = (c > reqEnd) && (c <= endC);
            inResp = (c >= respStart);
            req_rdy_down = inReq && (c >= reqDly);
            ack_vld_down = inAck && (c >= ackC);
            rd_data_down = ack_vld_down ? rdata : DW'($urandom);
            ack_rdy_up   = {N{inResp && (c >= lastC)}};
            #1;
            expCtrl = {inReq, inReq & eRd, inReq & eWr, inAck, inResp ? oh : N'(0),
                       inResp && abort && (c == respStart)};
            gotCtrl = {req_vld_down, rd_en_down, wr_en_down, ack_rdy_down, ack_vld_up, tmo_err};
            nChecks++;
            if (gotCtrl !== expCtrl)
                $display("[TB] FAIL ctrl c=%0d: got %b want %b", c, gotCtrl, expCtrl);
            else nPass++;
            if (inReq) begin
                nChecks++;
                if ({addr_down, wr_data_down, gnt_id} !== {ea, ed, GW'(w)})
                    $display("[TB] FAIL req_fields c=%0d: got %h/%h/%0d want %h/%h/%0d",
                             c, addr_down, wr_data_down, gnt_id, ea, ed, w);
                else nPass++;
            end
            if (inResp) begin
                nChecks++;
                if ({rd_data_up, gnt_id} !== {erd, GW'(w)})
                    $display("[TB] FAIL resp_data c=%0d: got %h/%0d want %h/%0d",
                             c, rd_data_up, gnt_id, erd, w);
                else nPass++;
            end
            @(posedge clk); #1;
        end
        req_rdy_down = 1'b0;
        ack_vld_down = 1'b0;
        ack_rdy_up   = '0;
        mdlPtr = (w + 1) % N;
        gotGnt = int'(gnt_id);
        nChecks++;
        if ({req_vld_down, ack_rdy_down, ack_vld_up, tmo_err} !== {1'b0, 1'b1, N'(0), 1'b0})
            $display("[TB] FAIL back_to_idle: got %b%b%b%b want 010..0",
                     req_vld_down, ack_rdy_down, ack_vld_up, tmo_err);
        else nPass++;
    endtask

    task automatic checkResetValues(input string tag);
        logic [RW-1:0] got, expv;
        got  = {req_vld_down, rd_en_down, wr_en_down, ack_rdy_down, ack_vld_up, tmo_err,
                gnt_id, rd_data_up, addr_down, wr_data_down};
        expv = {1'b0, 1'b0, 1'b0, 1'b1, N'(0), 1'b0, GW'(0), DW'(0), AW'(0), DW'(0)};
        nChecks++;
        if (got !== expv) $display("[TB] FAIL %s: got %h want %h", tag, got, expv);
        else nPass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkResetValues("reset_values");
        glb_srst_up = 1'b1;
        #1;
        nChecks++;
        if (glb_srst_down !== 1'b1) $display("[TB] FAIL srst_passthru_hi: got %b want 1", glb_srst_down);
        else nPass++;
        @(posedge clk); #1;
        glb_srst_up = 1'b0;
        #1;
        nChecks++;
        if (glb_srst_down !== 1'b0) $display("[TB] FAIL srst_passthru_lo: got %b want 0", glb_srst_down);
        else nPass++;
        mdlPtr = 0;
    endtask

    task automatic test_single_read();
        int g;
        randFields();
        addr_up[0 +: AW] = 64'h10;
        rd_en_up[0]      = 1'b1;
        wr_en_up[0]      = 1'b0;
        do_txn(3'b001, 0, 0, 0, 32'hA5A5_A5A5, g);
        nChecks++;
        if (g !== 0) $display("[TB] FAIL single_gnt: got %0d want 0", g);
        else nPass++;
    endtask

    task automatic test_fairness();
        int g, prev;
        int expSeq[4] = '{0, 1, 0, 1};
        test_reset();
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            randFields();
            do_txn(3'b011, 0, 0, 0, $urandom, g);
            nChecks++;
            if (g !== expSeq[k] || g == prev)
                $display("[TB] FAIL fair_seq[%0d]: got %0d want %0d", k, g, expSeq[k]);
            else nPass++;
            prev = g;
        end
    endtask

    task automatic test_backpressure();
        int g;
        randFields();
        do_txn(3'b001, 5, 3, 2, $urandom, g);
        randFields();
        do_txn(3'b110, 5, 3, 2, $urandom, g);
    endtask

    task automatic test_timeout();
        int g;
        randFields();
        do_txn(3'b100, 1000, 0, 0, 32'hDEAD_BEEF, g);
        randFields();
        do_txn(3'b001, TMO - 1, 0, 0, $urandom, g);
        randFields();
        do_txn(3'b010, 2, TMO - 4, 0, $urandom, g);
        randFields();
        do_txn(3'b001, 2, TMO - 3, 1, 32'hFFFF_FFFF, g);
        randFields();
        do_txn(3'b010, 0, 0, 0, $urandom, g);
    endtask

    task automatic test_random();
        int g;
        for (int k = 0; k < 24; k++) begin
            randFields();
            do_txn(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 6),
                   $urandom_range(0, 6), $urandom_range(0, 3), $urandom, g);
        end
    endtask

    task automatic test_reset_midtxn(input bit useGlb);
        int g;
        randFields();
        do_txn(3'b001, 0, 0, 0, $urandom, g);
        randFields();
        req_vld_up = 3'b011;
        #1;
        nChecks++;
        if (req_rdy_up !== 3'b010) $display("[TB] FAIL midrst_accept: got %b want 010", req_rdy_up);
        else nPass++;
        @(posedge clk); #1;
        req_vld_up   = '0;
        req_rdy_down = 1'b1;
        @(posedge clk); #1;
        req_rdy_down = 1'b0;
        nChecks++;
        if ({req_vld_down, ack_rdy_down, gnt_id} !== {1'b0, 1'b1, GW'(1)})
            $display("[TB] FAIL midrst_in_ack: got %b%b%0d want 01 1", req_vld_down, ack_rdy_down, gnt_id);
        else nPass++;
        if (useGlb) glb_srst_up = 1'b1;
        else rst_n = 1'b0;
        @(posedge clk); #1;
        glb_srst_up = 1'b0;
        rst_n       = 1'b1;
        checkResetValues(useGlb ? "glb_reset_values" : "rstn_reset_values");
        ack_vld_down = 1'b1;
        rd_data_down = $urandom;
        @(posedge clk); #1;
        ack_vld_down = 1'b0;
        for (int k = 0; k < 2; k++) begin
            nChecks++;
            if ({ack_vld_up, req_vld_down, ack_rdy_down, tmo_err} !== {N'(0), 1'b0, 1'b1, 1'b0})
                $display("[TB] FAIL stale_ack_drop: got %b%b%b%b want 0..0010",
                         ack_vld_up, req_vld_down, ack_rdy_down, tmo_err);
            else nPass++;
            @(posedge clk); #1;
        end
        mdlPtr = 0;
        randFields();
        do_txn(3'b011, 0, 0, 0, $urandom, g);
        nChecks++;
        if (g !== 0) $display("[TB] FAIL rr_ptr_after_reset: got %0d want 0", g);
        else nPass++;
    endtask

    initial begin
        rst_n        = 1'b0;
        glb_srst_up  = 1'b0;
        req_vld_up   = '0;
        rd_en_up     = '0;
        wr_en_up     = '0;
        addr_up      = '0;
        wr_data_up   = '0;
        ack_rdy_up   = '0;
        req_rdy_down = 1'b0;
        ack_vld_down = 1'b0;
        rd_data_down = '0;
        test_reset();
        test_single_read();
        test_fairness();
        test_backpressure();
        test_timeout();
        test_random();
        test_reset_midtxn(1'b0);
        test_reset_midtxn(1'b1);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
